// File: rtl/regfile_pkg.sv
// Shared constants and state type for the register-file port controller.
package regfile_pkg;

  localparam int NREG  = 16;
  localparam int WIDTH = 16;
  localparam int AW    = 4;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_t;

endpackage

// File: rtl/onehot_decoder.sv
// Binary index to one-hot row select; all-zero when not enabled.
module onehot_decoder #(
  parameter int AW   = 4,
  parameter int NREG = 16
) (
  input  logic            en,
  input  logic [AW-1:0]   idx,
  output logic [NREG-1:0] onehot
);

  // NOTE: assign a default before the conditional so no latch is inferred.
  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/regfile_port_ctrl.sv
// Port controller for the bitcell register-file array: post-reset clear,
// one-cycle write staging, one-hot read enables and read forwarding.
module regfile_port_ctrl #(
  parameter int NREG    = 16,
  parameter int WIDTH   = 16,
  parameter int AW      = 4,
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr1,
  input  logic [AW-1:0]    rd_addr2,
  output logic [WIDTH-1:0] row_d,
  output logic [NREG-1:0]  row_wen,
  output logic [NREG-1:0]  row_ren1,
  output logic [NREG-1:0]  row_ren2,
  input  logic [WIDTH-1:0] bitline1,
  input  logic [WIDTH-1:0] bitline2,
  output logic [WIDTH-1:0] rd_data1,
  output logic [WIDTH-1:0] rd_data2,
  output logic             ready
);

  import regfile_pkg::*;

  rf_state_t        state_q, state_d;
  logic [AW-1:0]    clr_cnt_q, clr_cnt_d;
  logic             stg_valid_q, stg_valid_d;
  logic [AW-1:0]    stg_addr_q, stg_addr_d;
  logic [WIDTH-1:0] stg_data_q, stg_data_d;

  logic             in_run;
  logic             wr_to_r0;
  logic             wdec_en;
  logic [AW-1:0]    wdec_idx;

  assign in_run   = (state_q == RUN);
  assign wr_to_r0 = ZERO_R0 && (wr_addr == '0);

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    stg_valid_d = 1'b0;
    stg_addr_d  = stg_addr_q;
    stg_data_d  = stg_data_q;
    unique case (state_q)
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == AW'(NREG - 1)) state_d = RUN;
      end
      RUN: begin
        stg_valid_d = wr_en && !wr_to_r0;
        stg_addr_d  = wr_addr;
        stg_data_d  = wr_data;
      end
      default: state_d = CLEAR;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= CLEAR;
      clr_cnt_q   <= '0;
      stg_valid_q <= 1'b0;
      stg_addr_q  <= '0;
      stg_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      stg_valid_q <= stg_valid_d;
      stg_addr_q  <= stg_addr_d;
      stg_data_q  <= stg_data_d;
    end
  end

  // Reset state is CLEAR with clr_cnt=0, so the write select must also be
  // gated by rst itself to keep row_wen quiet while reset is held.
  assign wdec_en  = rst && (!in_run || stg_valid_q);
  assign wdec_idx = in_run ? stg_addr_q : clr_cnt_q;
  assign row_d    = in_run ? stg_data_q : '0;
  assign ready    = in_run;

  onehot_decoder #(.AW(AW), .NREG(NREG)) u_wr_dec (
    .en     (wdec_en),
    .idx    (wdec_idx),
    .onehot (row_wen)
  );

  onehot_decoder #(.AW(AW), .NREG(NREG)) u_rd1_dec (
    .en     (in_run),
    .idx    (rd_addr1),
    .onehot (row_ren1)
  );

  onehot_decoder #(.AW(AW), .NREG(NREG)) u_rd2_dec (
    .en     (in_run),
    .idx    (rd_addr2),
    .onehot (row_ren2)
  );

  // Newest value wins: same-cycle write, then the staged write, then the array.
  function automatic logic [WIDTH-1:0] fwd_read(
    input logic [AW-1:0]    addr,
    input logic [WIDTH-1:0] bitline
  );
    logic [WIDTH-1:0] val;
    if (ZERO_R0 && (addr == '0))                val = '0;
    else if (wr_en && (wr_addr == addr))        val = wr_data;
    else if (stg_valid_q && (stg_addr_q == addr)) val = stg_data_q;
    else                                        val = bitline;
    return val;
  endfunction

  always_comb begin
    rd_data1 = '0;
    rd_data2 = '0;
    if (in_run) begin
      rd_data1 = fwd_read(rd_addr1, bitline1);
      rd_data2 = fwd_read(rd_addr2, bitline2);
    end
  end

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Scoreboard bench for regfile_port_ctrl with an emulated bitcell array and
// an architectural register-file reference model.
module tb_regfile_port_ctrl;

  localparam int NREG  = 16;
  localparam int WIDTH = 16;
  localparam int AW    = 4;

  logic             clk;
  logic             rst;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [AW-1:0]    rd_addr1, rd_addr2;
  logic [WIDTH-1:0] row_d;
  logic [NREG-1:0]  row_wen, row_ren1, row_ren2;
  logic [WIDTH-1:0] bitline1, bitline2;
  logic [WIDTH-1:0] rd_data1, rd_data2;
  logic             ready;

  regfile_port_ctrl #(.NREG(NREG), .WIDTH(WIDTH), .AW(AW), .ZERO_R0(1'b1)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr1 (rd_addr1),
    .rd_addr2 (rd_addr2),
    .row_d    (row_d),
    .row_wen  (row_wen),
    .row_ren1 (row_ren1),
    .row_ren2 (row_ren2),
    .bitline1 (bitline1),
    .bitline2 (bitline2),
    .rd_data1 (rd_data1),
    .rd_data2 (rd_data2),
    .ready    (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Emulated bitcell array: power-up garbage, captures row_d on row_wen.
  logic [WIDTH-1:0] mem [NREG];
  bit               mem_seeded = 1'b0;

  always @(posedge clk) begin
    if (!mem_seeded) begin
      for (int i = 0; i < NREG; i++) mem[i] <= WIDTH'($urandom);
      mem_seeded <= 1'b1;
    end else begin
      for (int i = 0; i < NREG; i++)
        if (row_wen[i]) mem[i] <= row_d;
    end
  end

  always_comb begin
    bitline1 = '0;
    bitline2 = '0;
    for (int i = 0; i < NREG; i++) begin
      if (row_ren1[i]) bitline1 = bitline1 | mem[i];
      if (row_ren2[i]) bitline2 = bitline2 | mem[i];
    end
  end

  typedef struct {
    logic             ready;
    logic [NREG-1:0]  wen;
    logic [NREG-1:0]  ren1;
    logic [NREG-1:0]  ren2;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check("ready",    32'(ready),    32'(mon_e.ready));
      check("row_wen",  32'(row_wen),  32'(mon_e.wen));
      check("row_ren1", 32'(row_ren1), 32'(mon_e.ren1));
      check("row_ren2", 32'(row_ren2), 32'(mon_e.ren2));
      check("row_d",    32'(row_d),    32'(mon_e.d));
      check("rd_data1", 32'(rd_data1), 32'(mon_e.rd1));
      check("rd_data2", 32'(rd_data2), 32'(mon_e.rd2));
    end
  end

  // Reference model: logical register contents plus the pending row write.
  logic [WIDTH-1:0] ref_reg [NREG];
  int               clr_idx;
  bit               model_run;
  bit               pend_valid;
  int               pend_addr;
  logic [WIDTH-1:0] last_d;

  function automatic logic [NREG-1:0] onehot(input int i);
    logic [NREG-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [WIDTH-1:0] model_read(input int a, input bit we, input int wa,
                                                  input logic [WIDTH-1:0] wd);
    if (a == 0)             return '0;
    if (we && (wa == a))    return wd;
    return ref_reg[a];
  endfunction

  task automatic step(input bit we, input int wa, input logic [WIDTH-1:0] wd,
                      input int a1, input int a2);
    exp_t e;
    wr_en    = we;
    wr_addr  = AW'(wa);
    wr_data  = wd;
    rd_addr1 = AW'(a1);
    rd_addr2 = AW'(a2);
    if (!model_run) begin
      e.ready = 1'b0;
      e.wen   = onehot(clr_idx);
      e.ren1  = '0;
      e.ren2  = '0;
      e.d     = '0;
      e.rd1   = '0;
      e.rd2   = '0;
    end else begin
      e.ready = 1'b1;
      e.wen   = pend_valid ? onehot(pend_addr) : '0;
      e.ren1  = onehot(a1);
      e.ren2  = onehot(a2);
      e.d     = last_d;
      e.rd1   = model_read(a1, we, wa, wd);
      e.rd2   = model_read(a2, we, wa, wd);
    end
    exp_q.push_back(e);
    @(posedge clk);
    if (!model_run) begin
      clr_idx++;
      if (clr_idx == NREG) model_run = 1'b1;
    end else begin
      pend_valid = we && (wa != 0);
      pend_addr  = wa;
      last_d     = wd;
      if (we && (wa != 0)) ref_reg[wa] = wd;
    end
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    #1;
    check("rst_ready",    32'(ready),    32'd0);
    check("rst_row_wen",  32'(row_wen),  32'd0);
    check("rst_row_ren1", 32'(row_ren1), 32'd0);
    check("rst_row_ren2", 32'(row_ren2), 32'd0);
    check("rst_row_d",    32'(row_d),    32'd0);
    check("rst_rd_data1", 32'(rd_data1), 32'd0);
    check("rst_rd_data2", 32'(rd_data2), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst        = 1'b1;
    clr_idx    = 0;
    model_run  = 1'b0;
    pend_valid = 1'b0;
    pend_addr  = 0;
    last_d     = '0;
    for (int i = 0; i < NREG; i++) ref_reg[i] = '0;
  endtask

  task automatic random_steps(input int n);
    for (int k = 0; k < n; k++) begin
      int hi;
      hi = ($urandom_range(0, 3) == 0) ? 3 : NREG - 1;
      step($urandom_range(0, 1) == 1, $urandom_range(0, hi), WIDTH'($urandom),
           $urandom_range(0, hi), $urandom_range(0, hi));
    end
  endtask

  initial begin
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr1 = '0; rd_addr2 = '0;
    apply_reset();

    // Clear sequence with write requests that must be dropped.
    for (int c = 0; c < NREG; c++)
      step(1'b1, $urandom_range(1, NREG - 1), WIDTH'($urandom), c, 15 - c);

    // Forward, staged, then array read of r5.
    step(1'b1, 5, 16'hBEEF, 5, 0);
    step(1'b0, 0, 16'h0000, 5, 5);
    step(1'b0, 0, 16'h0000, 5, 7);

    // Back-to-back writes to r3.
    step(1'b1, 3, 16'h1111, 1, 3);
    step(1'b1, 3, 16'h2222, 2, 3);
    step(1'b0, 0, 16'h0000, 3, 3);
    step(1'b0, 0, 16'h0000, 4, 3);

    // Writes to r0 are dropped and r0 reads zero.
    step(1'b1, 0, 16'hFFFF, 0, 0);
    step(1'b0, 0, 16'h0000, 0, 0);
    step(1'b0, 0, 16'h0000, 0, 5);

    random_steps(400);

    // Reset in the middle of a clear, then a full clear again.
    apply_reset();
    for (int c = 0; c < 7; c++) step(1'b0, 0, 16'h0000, 0, 0);
    check("clr_cnt7_row_wen", 32'(row_wen), 32'h0080);
    #2;
    apply_reset();
    for (int c = 0; c < NREG; c++) step(1'b1, c, WIDTH'($urandom), 0, 0);

    // Unwritten rows must read the cleared array.
    for (int r = 0; r < NREG; r += 2) step(1'b0, 0, 16'h0000, r, r + 1);
    random_steps(100);

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/regfile_port_ctrl.md
# regfile_port_ctrl

Port controller for the bitcell register-file array: it sits directly upstream of the bitcell rows and drives every row's `d`, `wen`, `ren1` and `ren2` line. It also consumes the two shared bitlines. The block stages one write per cycle, decodes two read addresses into one-hot read enables, and forwards in-flight write data so reads always see the newest value. After reset it sequentially clears every row before accepting traffic.

## Interface
Parameters:
- NREG, 16, number of register rows
- WIDTH, 16, bits per register
- AW, 4, address width; NREG == 2**AW
- ZERO_R0, 1, when 1, register 0 reads as zero and ignores writes

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- wr_en  in  1  write request this cycle
- wr_addr  in  AW  write register index
- wr_data  in  WIDTH  write data
- rd_addr1  in  AW  read port 1 index
- rd_addr2  in  AW  read port 2 index
- row_d  out  WIDTH  write data broadcast to all rows' `d`
- row_wen  out  NREG  one-hot-or-zero row write enable
- row_ren1  out  NREG  one-hot-or-zero row read enable, port 1
- row_ren2  out  NREG  one-hot-or-zero row read enable, port 2
- bitline1  in  WIDTH  shared array bitline, port 1
- bitline2  in  WIDTH  shared array bitline, port 2
- rd_data1  out  WIDTH  read result, port 1
- rd_data2  out  WIDTH  read result, port 2
- ready  out  1  high once clear sequence is done; write requests are honoured only when high

## Operation
- FSM states: CLEAR, RUN.
- Reset (rst low, any time, asynchronous) forces the following:
  - state=CLEAR, clr_cnt=0, stg_valid=0, stg_addr=0, stg_data=0.
  - Outputs: ready=0, row_wen=0, row_ren1=0, row_ren2=0, row_d=0, rd_data1=0, rd_data2=0.
- CLEAR state:
  - Each cycle: row_wen = onehot(clr_cnt), row_d = 0.
  - clr_cnt increments by 1 each cycle.
  - When clr_cnt == NREG-1, the next state is RUN.
  - wr_en is ignored. row_ren1, row_ren2, rd_data1 and rd_data2 stay 0.
- RUN state:
  - ready = 1.
  - Write staging: on each edge, stg_valid <= wr_en and not (ZERO_R0 and wr_addr==0); stg_addr <= wr_addr; stg_data <= wr_data.
  - Row drive: row_wen = stg_valid ? onehot(stg_addr) : 0; row_d = stg_data.
  - Read enables: row_ren1 = onehot(rd_addr1) and row_ren2 = onehot(rd_addr2), always exactly one bit set.
  - Read data priority, per port (addr = rd_addr1 or rd_addr2), evaluated combinationally:
    1. ZERO_R0 and addr==0 → 0.
    2. wr_en and wr_addr==addr → wr_data (same-cycle forward).
    3. stg_valid and stg_addr==addr → stg_data.
    4. Otherwise → bitline.
- Both ports may read the same address; both receive identical data.
- RUN has no exit except reset.

## Timing
- A write requested in cycle N is registered at the end of N.
  - row_wen is asserted during N+1.
  - The bitcell captures it at the end of N+1.
  - The array value is visible on the bitline from N+2.
- Read latency is 0 cycles; read outputs are combinational from address, forwarding paths and bitlines.
- Back-to-back writes to the same address: forwarding priority 2 beats 3, so the newest value always wins.
- Clear takes exactly NREG cycles after rst deasserts; ready rises in cycle NREG, counting the first post-reset cycle as 0.
- Reset asserted mid-clear or mid-write aborts immediately. A staged write is discarded and clear restarts from 0.

## Structure
- Shared package `regfile_pkg` holds:
  - Constants NREG, WIDTH, AW.
  - State enum `rf_state_t` {CLEAR, RUN}.
- Sub-module `onehot_decoder` (AW→NREG) is instantiated three times: write, read port 1, read port 2.
- Forwarding mux and FSM live in the top module.

## Test plan
- Reset release → ready=0 for 16 cycles; row_wen walks 0x0001…0x8000 with row_d=0; ready=1 in cycle 16.
- In RUN, write r5=0xBEEF in cycle N with rd_addr1=5:
  - rd_data1=0xBEEF in N (forward).
  - rd_data1=0xBEEF in N+1 (staged); row_wen=0x0020 in N+1.
  - rd_data1 = bitline value in N+2.
- Writes r3=0x1111 then r3=0x2222 on consecutive cycles, rd_addr2=3 → 0x1111 in cycle 1, 0x2222 in cycles 2 and 3.
- ZERO_R0=1, write r0=0xFFFF → row_wen stays 0; rd_data1 and rd_data2 = 0 when reading r0.
- wr_en=1 during CLEAR → no extra row_wen bit set; the write is lost.
- rst pulsed low mid-clear at clr_cnt=7 → all outputs 0 immediately; full 16-cycle clear repeats.
